// File: rtl/regbank_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single rw-muxed port of the
// 8x8 register bank. Supports lock-based atomic ownership and one-cycle read responses.
module regbank_arbiter #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [IDX_W-1:0]  p0_req_ri_a,
    input  logic [IDX_W-1:0]  p0_req_ri_b,
    input  logic [IDX_W-1:0]  p0_req_ri_d,
    input  logic [DATA_W-1:0] p0_req_d,
    input  logic              p0_req_lock,
    output logic              p0_rsp_valid,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [IDX_W-1:0]  p1_req_ri_a,
    input  logic [IDX_W-1:0]  p1_req_ri_b,
    input  logic [IDX_W-1:0]  p1_req_ri_d,
    input  logic [DATA_W-1:0] p1_req_d,
    input  logic              p1_req_lock,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] rsp_a,
    output logic [DATA_W-1:0] rsp_b,
    output logic              bank_rw,
    output logic [IDX_W-1:0]  bank_ri_a,
    output logic [IDX_W-1:0]  bank_ri_b,
    output logic [IDX_W-1:0]  bank_ri_d,
    output logic [DATA_W-1:0] bank_d,
    input  logic [DATA_W-1:0] bank_a,
    input  logic [DATA_W-1:0] bank_b,
    output logic [1:0]        dbg_owner
);

    // Handshake: a request transfers at the posedge where req_valid & req_ready are both 1;
    // ready is combinational from valid, owner and prio. rsp_valid pulses for one cycle with no backpressure.

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    owner_t             owner_q, owner_d;
    logic               prio_q, prio_d;
    logic [IDX_W-1:0]   last_a_q, last_a_d;
    logic [IDX_W-1:0]   last_b_q, last_b_d;
    logic               rsp0_q, rsp1_q;
    logic               gnt0, gnt1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case (owner_q)
                OWN_P0: gnt0 = p0_req_valid;
                OWN_P1: gnt1 = p1_req_valid;
                default: begin
                    if (p0_req_valid && p1_req_valid) begin
                        gnt0 = !prio_q;
                        gnt1 = prio_q;
                    end else begin
                        gnt0 = p0_req_valid;
                        gnt1 = p1_req_valid;
                    end
                end
            endcase
        end
    end

    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;

    // Idle cycles repeat the last read so the bank outputs (and rsp_a/rsp_b) stay put.
    always_comb begin
        bank_rw   = 1'b0;
        bank_ri_a = last_a_q;
        bank_ri_b = last_b_q;
        bank_ri_d = '0;
        bank_d    = '0;
        owner_d   = owner_q;
        prio_d    = prio_q;
        last_a_d  = last_a_q;
        last_b_d  = last_b_q;
        if (gnt0) begin
            bank_rw   = p0_req_we;
            bank_ri_a = p0_req_ri_a;
            bank_ri_b = p0_req_ri_b;
            bank_ri_d = p0_req_ri_d;
            bank_d    = p0_req_d;
            prio_d    = 1'b1;
            owner_d   = p0_req_lock ? OWN_P0 : OWN_NONE;
            if (!p0_req_we) begin
                last_a_d = p0_req_ri_a;
                last_b_d = p0_req_ri_b;
            end
        end else if (gnt1) begin
            bank_rw   = p1_req_we;
            bank_ri_a = p1_req_ri_a;
            bank_ri_b = p1_req_ri_b;
            bank_ri_d = p1_req_ri_d;
            bank_d    = p1_req_d;
            prio_d    = 1'b0;
            owner_d   = p1_req_lock ? OWN_P1 : OWN_NONE;
            if (!p1_req_we) begin
                last_a_d = p1_req_ri_a;
                last_b_d = p1_req_ri_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            prio_q   <= 1'b0;
            last_a_q <= '0;
            last_b_q <= '0;
            rsp0_q   <= 1'b0;
            rsp1_q   <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            last_a_q <= last_a_d;
            last_b_q <= last_b_d;
            rsp0_q   <= gnt0 && !p0_req_we;
            rsp1_q   <= gnt1 && !p1_req_we;
        end
    end

    assign p0_rsp_valid = rsp0_q;
    assign p1_rsp_valid = rsp1_q;
    assign rsp_a        = bank_a;
    assign rsp_b        = bank_b;
    assign dbg_owner    = owner_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: behavioural bank, arbiter reference model and
// per-port expected-response queues, plus directed scenarios and a random run.
module tb_regbank_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       p0_req_valid, p0_req_ready, p0_req_we, p0_req_lock, p0_rsp_valid;
    logic [2:0] p0_req_ri_a, p0_req_ri_b, p0_req_ri_d;
    logic [7:0] p0_req_d;
    logic       p1_req_valid, p1_req_ready, p1_req_we, p1_req_lock, p1_rsp_valid;
    logic [2:0] p1_req_ri_a, p1_req_ri_b, p1_req_ri_d;
    logic [7:0] p1_req_d;
    logic [7:0] rsp_a, rsp_b, bank_d;
    logic       bank_rw;
    logic [2:0] bank_ri_a, bank_ri_b, bank_ri_d;
    logic [7:0] bank_a = 8'h00;
    logic [7:0] bank_b = 8'h00;
    logic [1:0] dbg_owner;

    logic [7:0] mem [8] = '{default: 8'h00};

    int checks = 0;
    int errors = 0;

    // reference model state
    int         m_owner = 0;
    bit         m_prio = 1'b0;
    bit         pend0 = 1'b0, pend1 = 1'b0;
    logic [7:0] ref_mem [8] = '{default: 8'h00};
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    always #5 clk = ~clk;

    regbank_arbiter #(.DATA_W(8), .IDX_W(3)) dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_ri_a(p0_req_ri_a), .p0_req_ri_b(p0_req_ri_b), .p0_req_ri_d(p0_req_ri_d),
        .p0_req_d(p0_req_d), .p0_req_lock(p0_req_lock), .p0_rsp_valid(p0_rsp_valid),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_ri_a(p1_req_ri_a), .p1_req_ri_b(p1_req_ri_b), .p1_req_ri_d(p1_req_ri_d),
        .p1_req_d(p1_req_d), .p1_req_lock(p1_req_lock), .p1_rsp_valid(p1_rsp_valid),
        .rsp_a(rsp_a), .rsp_b(rsp_b), .bank_rw(bank_rw),
        .bank_ri_a(bank_ri_a), .bank_ri_b(bank_ri_b), .bank_ri_d(bank_ri_d),
        .bank_d(bank_d), .bank_a(bank_a), .bank_b(bank_b), .dbg_owner(dbg_owner)
    );

    // bank: one write or one registered dual read per edge, contents never reset
    always @(posedge clk) begin
        if (bank_rw) begin
            mem[bank_ri_d] <= bank_d;
        end else begin
            bank_a <= mem[bank_ri_a];
            bank_b <= mem[bank_ri_b];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_p0(input logic v, input logic we, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] dd, input logic [7:0] d, input logic lk);
        p0_req_valid = v; p0_req_we = we; p0_req_ri_a = a; p0_req_ri_b = b;
        p0_req_ri_d = dd; p0_req_d = d; p0_req_lock = lk;
    endtask

    task automatic set_p1(input logic v, input logic we, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] dd, input logic [7:0] d, input logic lk);
        p1_req_valid = v; p1_req_we = we; p1_req_ri_a = a; p1_req_ri_b = b;
        p1_req_ri_d = dd; p1_req_d = d; p1_req_lock = lk;
    endtask

    task automatic drive_idle();
        set_p0(0, 0, 0, 0, 0, 8'h00, 0);
        set_p1(0, 0, 0, 0, 0, 8'h00, 0);
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_prio  = 1'b0;
        pend0   = 1'b0;
        pend1   = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // One clock cycle from negedge to negedge with the currently driven inputs.
    task automatic step(output logic r0, output logic r1);
        bit g0, g1;
        logic [15:0] e;
        #1;
        g0 = p0_req_valid && (m_owner == 1 || (m_owner == 0 && (!p1_req_valid || !m_prio)));
        g1 = p1_req_valid && (m_owner == 2 || (m_owner == 0 && (!p0_req_valid || m_prio)));
        r0 = p0_req_ready;
        r1 = p1_req_ready;
        check("ready0", {31'd0, p0_req_ready}, {31'd0, g0});
        check("ready1", {31'd0, p1_req_ready}, {31'd0, g1});
        check("bank_rw", {31'd0, bank_rw}, {31'd0, (g0 && p0_req_we) || (g1 && p1_req_we)});
        @(posedge clk);
        if (g0) begin
            if (p0_req_we) ref_mem[p0_req_ri_d] = p0_req_d;
            else exp_q0.push_back({ref_mem[p0_req_ri_a], ref_mem[p0_req_ri_b]});
            m_prio  = 1'b1;
            m_owner = p0_req_lock ? 1 : 0;
        end else if (g1) begin
            if (p1_req_we) ref_mem[p1_req_ri_d] = p1_req_d;
            else exp_q1.push_back({ref_mem[p1_req_ri_a], ref_mem[p1_req_ri_b]});
            m_prio  = 1'b0;
            m_owner = p1_req_lock ? 2 : 0;
        end
        pend0 = g0 && !p0_req_we;
        pend1 = g1 && !p1_req_we;
        @(negedge clk);
        check("rsp_valid0", {31'd0, p0_rsp_valid}, {31'd0, pend0});
        check("rsp_valid1", {31'd0, p1_rsp_valid}, {31'd0, pend1});
        if (pend0 && exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            check("rsp0_data", {16'd0, rsp_a, rsp_b}, {16'd0, e});
        end
        if (pend1 && exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            check("rsp1_data", {16'd0, rsp_a, rsp_b}, {16'd0, e});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_p0(1, 0, 1, 1, 0, 8'h00, 0);
        set_p1(1, 1, 0, 0, 4, 8'hEE, 0);
        #1;
        check("rst_ready0", {31'd0, p0_req_ready}, 0);
        check("rst_ready1", {31'd0, p1_req_ready}, 0);
        check("rst_bank_rw", {31'd0, bank_rw}, 0);
        check("rst_rsp0", {31'd0, p0_rsp_valid}, 0);
        @(negedge clk);
        @(negedge clk);
        drive_idle();
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        logic r0, r1;
        logic [3:0] alt_exp;
        alt_exp = 4'b0101;
        drive_idle();
        @(negedge clk);
        do_reset();

        // write then read back
        set_p0(1, 1, 0, 0, 2, 8'h5A, 0);
        step(r0, r1);
        set_p0(1, 0, 2, 0, 0, 8'h00, 0);
        step(r0, r1);
        check("wr_rd_a", {24'd0, rsp_a}, 32'h5A);
        check("wr_rd_b", {24'd0, rsp_b}, 32'h00);
        drive_idle();
        step(r0, r1);

        // round robin from reset
        do_reset();
        set_p0(1, 0, 2, 1, 0, 8'h00, 0);
        set_p1(1, 0, 0, 2, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            step(r0, r1);
            check("alt_g0", {31'd0, r0}, {31'd0, alt_exp[i]});
            check("alt_g1", {31'd0, r1}, {31'd0, !alt_exp[i]});
        end
        drive_idle();
        step(r0, r1);

        // lock holds p0 off until unlock
        set_p1(1, 1, 0, 0, 1, 8'h11, 1);
        step(r0, r1);
        check("owner_p1", {30'd0, dbg_owner}, 32'd2);
        set_p1(0, 0, 0, 0, 0, 8'h00, 0);
        set_p0(1, 0, 1, 1, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            step(r0, r1);
            check("lock_hold", {31'd0, r0}, 0);
        end
        set_p1(1, 1, 0, 0, 1, 8'h22, 0);
        step(r0, r1);
        check("unlock_p1", {31'd0, r1}, 1);
        set_p1(0, 0, 0, 0, 0, 8'h00, 0);
        step(r0, r1);
        check("after_unlock", {31'd0, r0}, 1);
        check("r1_new", {24'd0, rsp_a}, 32'h22);

        // idle cycles and a write keep the last read data on rsp_a
        set_p0(1, 1, 0, 0, 3, 8'h77, 0);
        step(r0, r1);
        set_p0(1, 0, 3, 3, 0, 8'h00, 0);
        step(r0, r1);
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            step(r0, r1);
            check("hold_idle", {24'd0, rsp_a}, 32'h77);
        end
        set_p1(1, 1, 0, 0, 3, 8'h00, 0);
        step(r0, r1);
        check("hold_write", {24'd0, rsp_a}, 32'h77);
        drive_idle();
        step(r0, r1);

        // reset right after a read handshake drops the response
        set_p0(1, 0, 2, 2, 0, 8'h00, 0);
        #1;
        check("pre_rst_gnt", {31'd0, p0_req_ready}, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_drop_rsp", {31'd0, p0_rsp_valid}, 0);
        check("rst_drop_rdy", {31'd0, p0_req_ready}, 0);
        @(negedge clk);
        drive_idle();
        model_reset();
        rst = 1'b0;
        set_p0(1, 0, 2, 2, 0, 8'h00, 0);
        step(r0, r1);
        check("keep_r2", {24'd0, rsp_a}, 32'h5A);

        // lone p1 granted while prio points at it, then prio returns to p0
        set_p0(0, 0, 0, 0, 0, 8'h00, 0);
        set_p1(1, 0, 1, 2, 0, 8'h00, 0);
        step(r0, r1);
        check("lone_p1", {31'd0, r1}, 1);
        set_p0(1, 0, 3, 2, 0, 8'h00, 0);
        step(r0, r1);
        check("prio_back_p0", {31'd0, r0}, 1);

        // random traffic against the model
        for (int i = 0; i < 80; i++) begin
            set_p0($urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                   $urandom_range(0, 5) == 0);
            set_p1($urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                   $urandom_range(0, 5) == 0);
            step(r0, r1);
        end
        drive_idle();
        step(r0, r1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regbank_arbiter.md
Name: regbank_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the DiBU 8-entry x 8-bit register bank.
- The bank has one rw-muxed port: each clk edge does either one write or one dual read.
- This block shares that port between port 0 (core execute/writeback) and port 1 (debug/load unit).
- It uses valid/ready request handshakes, round-robin fairness, optional lock for atomic sequences, and one-cycle-latency read responses.

Parameters:
- DATA_W, 8, register data width
- IDX_W, 3, register index width

Ports:
- clk  in  1  main clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- pN_req_valid  in  1  request present (N = 0, 1; same set per port)
- pN_req_ready  out  1  grant; handshake = valid & ready at posedge
- pN_req_we  in  1  1 = write, 0 = dual read
- pN_req_ri_a, pN_req_ri_b  in  IDX_W  read indices
- pN_req_ri_d  in  IDX_W  write index
- pN_req_d  in  DATA_W  write data
- pN_req_lock  in  1  keep ownership after this handshake
- pN_rsp_valid  out  1  read data for port N valid this cycle
- rsp_a, rsp_b  out  DATA_W  read data, shared, direct from bank_a/bank_b
- bank_rw  out  1  to bank rw
- bank_ri_a, bank_ri_b, bank_ri_d  out  IDX_W  to bank indices
- bank_d  out  DATA_W  to bank d
- bank_a, bank_b  in  DATA_W  bank read outputs

Behaviour:
- Reset: reset is asynchronous and active-high (rst); clock is clk.
- While rst = 1: pN_req_ready = 0, pN_rsp_valid = 0, bank_rw = 0.
- rst clears: prio = 0, owner = none, last_ri_a = last_ri_b = 0.
- Bank contents are not reset.
- Grant (combinational, at most one port):
  - If owner = N, only port N may be granted; the other port is held off.
  - Else if both ports are valid, grant port prio.
  - Else grant whichever port is valid.
- Priority update on a handshake by port N: prio <= 1-N, applied whether or not the other port was waiting.
- Lock: a handshake with lock = 1 sets owner <= N.
  - owner clears on port N's next handshake with lock = 0.
  - Owner with valid = 0 stalls the other port indefinitely (by design).
- Bank drive, granted cycle:
  - bank_rw = req_we.
  - Indices and d come from the granted port's request.
  - On a read grant, last_ri_a/last_ri_b <= granted read indices.
- Bank drive, idle cycle (no grant):
  - bank_rw = 0, bank_ri_a/b = last_ri_a/b, bank_d = 0, bank_ri_d = 0.
  - The repeated read keeps rsp_a/rsp_b stable.
- Write: completes at the handshake edge; no response pulse.
- Read: handshake at edge k gives pN_rsp_valid = 1 for exactly the cycle after edge k.
  - rsp_a/rsp_b hold bank[ri_a]/bank[ri_b] in that cycle.
  - No response backpressure.
- Hazards:
  - A read granted the cycle after a write to the same index returns the new value; no bypass needed.
  - A read and a write to the same register cannot be granted in the same cycle.
- Throughput: one operation per cycle; back-to-back reads give a response every cycle.
- Reset mid-operation:
  - A pending pN_rsp_valid is dropped.
  - A write whose edge coincides with rst assertion is not guaranteed to occur.

Test Plan:
- Reset, then p0 write ri_d = 2, d = 8'h5A; next cycle p0 read ri_a = 2, ri_b = 0 -> p0_rsp_valid one cycle later, rsp_a = 8'h5A, rsp_b = 8'h00.
- p0 and p1 both hold valid reads for 4 cycles after reset -> grants alternate p0, p1, p0, p1; each rsp_valid pulses the cycle after its grant.
- p1 lock = 1 write r1 = 8'h11, then p1 idle 3 cycles with p0 valid -> p0_req_ready stays 0.
  - Then p1 write lock = 0 r1 = 8'h22 -> p0 granted next cycle; its read of r1 returns 8'h22.
- Read r3 (= 8'h77), then 3 idle cycles, then p1 writes r3 = 8'h00 -> rsp_a stays 8'h77 across the idle cycles and the write cycle.
- Assert rst in the cycle after a read handshake -> p0_rsp_valid = 0 immediately.
  - Bank keeps its data: a post-reset read of r2 = 8'h5A returns 8'h5A.
- Only p1 valid, prio = 1 after a p0 handshake -> p1 granted at once; prio becomes 0.
